// File: rtl/pipelined_decode_stage_if.sv
// Bundle between the IF/ID latch, control, forwarding sources and the ID/EX register.
// AW must equal $clog2(NREG) of the attached decode stage.
interface pipelined_decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc4;

  logic [1:0]      ctl_regdst;
  logic            ctl_regwr;
  logic            ctl_memrd;
  logic            ctl_memwr;
  logic            ctl_sign;
  logic            ctl_extop;
  logic            ctl_luop;
  logic            ctl_alusrc1;
  logic            ctl_alusrc2;
  logic [5:0]      ctl_alufun;
  logic [1:0]      ctl_memtoreg;

  logic            exm_wr;
  logic [AW-1:0]   exm_addr;
  logic [XLEN-1:0] exm_data;
  logic            mwb_wr;
  logic [AW-1:0]   mwb_addr;
  logic [XLEN-1:0] mwb_data;

  logic            ex_ready;
  logic            flush;
  logic            stall_if;

  logic            idex_valid;
  logic [XLEN-1:0] idex_a;
  logic [XLEN-1:0] idex_b;
  logic [XLEN-1:0] idex_st;
  logic [XLEN-1:0] idex_conba;
  logic [AW-1:0]   idex_dst;
  logic            idex_regwr;
  logic            idex_memrd;
  logic            idex_memwr;
  logic            idex_sign;
  logic [5:0]      idex_alufun;
  logic [1:0]      idex_memtoreg;

  modport master (
    output if_valid, if_instr, if_pc4,
    output ctl_regdst, ctl_regwr, ctl_memrd, ctl_memwr, ctl_sign, ctl_extop, ctl_luop,
    output ctl_alusrc1, ctl_alusrc2, ctl_alufun, ctl_memtoreg,
    output exm_wr, exm_addr, exm_data, mwb_wr, mwb_addr, mwb_data,
    output ex_ready, flush,
    input  stall_if,
    input  idex_valid, idex_a, idex_b, idex_st, idex_conba, idex_dst,
    input  idex_regwr, idex_memrd, idex_memwr, idex_sign, idex_alufun, idex_memtoreg
  );

  modport slave (
    input  if_valid, if_instr, if_pc4,
    input  ctl_regdst, ctl_regwr, ctl_memrd, ctl_memwr, ctl_sign, ctl_extop, ctl_luop,
    input  ctl_alusrc1, ctl_alusrc2, ctl_alufun, ctl_memtoreg,
    input  exm_wr, exm_addr, exm_data, mwb_wr, mwb_addr, mwb_data,
    input  ex_ready, flush,
    output stall_if,
    output idex_valid, idex_a, idex_b, idex_st, idex_conba, idex_dst,
    output idex_regwr, idex_memrd, idex_memwr, idex_sign, idex_alufun, idex_memtoreg
  );
endinterface

// File: rtl/pipelined_decode_stage.sv
// ID stage: register file with write-through, EX/MEM and MEM/WB forwarding, operand
// muxing, branch target, load-use bubble and the ID/EX pipeline register.
module pipelined_decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned RA_IDX = 31,
  parameter int unsigned XP_IDX = 26
) (
  input logic                    clk,
  input logic                    reset,
  pipelined_decode_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic            regwr;
    logic            memrd;
    logic            memwr;
    logic            sign;
    logic [5:0]      alufun;
    logic [1:0]      memtoreg;
    logic [AW-1:0]   dst;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] st;
    logic [XLEN-1:0] conba;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREG];

  logic [AW-1:0]   rs, rt, rd;
  logic [4:0]      shamt;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm32;
  logic [XLEN-1:0] fwd_rs, fwd_rt;
  logic            lu;
  logic            unused_opcode;

  idex_t dec;
  idex_t idex_d, idex_q;

  assign rs            = AW'(bus.if_instr[25:21]);
  assign rt            = AW'(bus.if_instr[20:16]);
  assign rd            = AW'(bus.if_instr[15:11]);
  assign shamt         = bus.if_instr[10:6];
  assign imm16         = bus.if_instr[15:0];
  assign unused_opcode = ^bus.if_instr[31:26];

  assign imm32 = bus.ctl_extop ? {{(XLEN-16){imm16[15]}}, imm16} : XLEN'(imm16);

  // r0 first, then the younger EX/MEM result, then MEM/WB (which doubles as the
  // same-cycle write-through of the register file write port).
  function automatic logic [XLEN-1:0] fwd(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] rf_val,
    input logic            exm_wr,
    input logic [AW-1:0]   exm_addr,
    input logic [XLEN-1:0] exm_data,
    input logic            mwb_wr,
    input logic [AW-1:0]   mwb_addr,
    input logic [XLEN-1:0] mwb_data
  );
    if (addr == '0) begin
      return '0;
    end else if (exm_wr && exm_addr == addr) begin
      return exm_data;
    end else if (mwb_wr && mwb_addr == addr) begin
      return mwb_data;
    end else begin
      return rf_val;
    end
  endfunction

  assign fwd_rs = fwd(rs, rf_q[rs], bus.exm_wr, bus.exm_addr, bus.exm_data,
                      bus.mwb_wr, bus.mwb_addr, bus.mwb_data);
  assign fwd_rt = fwd(rt, rf_q[rt], bus.exm_wr, bus.exm_addr, bus.exm_data,
                      bus.mwb_wr, bus.mwb_addr, bus.mwb_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.mwb_wr && bus.mwb_addr != '0) begin
      rf_q[bus.mwb_addr] <= bus.mwb_data;
    end
  end

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.regwr    = bus.ctl_regwr;
    dec.memrd    = bus.ctl_memrd;
    dec.memwr    = bus.ctl_memwr;
    dec.sign     = bus.ctl_sign;
    dec.alufun   = bus.ctl_alufun;
    dec.memtoreg = bus.ctl_memtoreg;
    dec.a        = bus.ctl_alusrc1 ? XLEN'(shamt) : fwd_rs;
    if (!bus.ctl_alusrc2) begin
      dec.b = fwd_rt;
    end else if (bus.ctl_luop) begin
      dec.b = XLEN'({imm16, 16'h0000});
    end else begin
      dec.b = imm32;
    end
    dec.st    = fwd_rt;
    dec.conba = (imm32 << 2) + bus.if_pc4;
    unique case (bus.ctl_regdst)
      2'b00:   dec.dst = rd;
      2'b01:   dec.dst = rt;
      2'b10:   dec.dst = AW'(RA_IDX);
      default: dec.dst = AW'(XP_IDX);
    endcase
  end

  // Both source fields are compared even when the instruction ignores rt; the
  // occasional false stall is cheaper than decoding operand usage here.
  assign lu = idex_q.valid & idex_q.memrd & (idex_q.dst != '0) &
              ((idex_q.dst == rs) | (idex_q.dst == rt));

  assign bus.stall_if = ~reset & ~bus.flush & (~bus.ex_ready | lu);

  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = '0;
    end else if (!bus.ex_ready) begin
      idex_d = idex_q;
    end else if (lu || !bus.if_valid) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.idex_valid    = idex_q.valid;
  assign bus.idex_regwr    = idex_q.regwr;
  assign bus.idex_memrd    = idex_q.memrd;
  assign bus.idex_memwr    = idex_q.memwr;
  assign bus.idex_sign     = idex_q.sign;
  assign bus.idex_alufun   = idex_q.alufun;
  assign bus.idex_memtoreg = idex_q.memtoreg;
  assign bus.idex_dst      = idex_q.dst;
  assign bus.idex_a        = idex_q.a;
  assign bus.idex_b        = idex_q.b;
  assign bus.idex_st       = idex_q.st;
  assign bus.idex_conba    = idex_q.conba;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: vector table plus hand-written
// sequences for stall, flush, hold and reset behaviour.
module tb_pipelined_decode_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipelined_decode_stage_if #(.XLEN(32), .AW(5)) bus ();

  pipelined_decode_stage #(
    .XLEN  (32),
    .NREG  (32),
    .RA_IDX(31),
    .XP_IDX(26)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] pc4;
    logic [1:0]  regdst;
    logic        regwr, memwr, extop, luop, src1, src2;
    logic [5:0]  alufun;
    logic        exm_wr;
    logic [4:0]  exm_addr;
    logic [31:0] exm_data;
    logic        mwb_wr;
    logic [4:0]  mwb_addr;
    logic [31:0] mwb_data;
    logic [31:0] exp_a, exp_b, exp_st, exp_conba;
    logic [4:0]  exp_dst;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid     = 1'b0;
    bus.if_instr     = 32'h0;
    bus.if_pc4       = 32'h0;
    bus.ctl_regdst   = 2'b00;
    bus.ctl_regwr    = 1'b0;
    bus.ctl_memrd    = 1'b0;
    bus.ctl_memwr    = 1'b0;
    bus.ctl_sign     = 1'b0;
    bus.ctl_extop    = 1'b0;
    bus.ctl_luop     = 1'b0;
    bus.ctl_alusrc1  = 1'b0;
    bus.ctl_alusrc2  = 1'b0;
    bus.ctl_alufun   = 6'h0;
    bus.ctl_memtoreg = 2'b00;
    bus.exm_wr       = 1'b0;
    bus.exm_addr     = 5'd0;
    bus.exm_data     = 32'h0;
    bus.mwb_wr       = 1'b0;
    bus.mwb_addr     = 5'd0;
    bus.mwb_data     = 32'h0;
    bus.ex_ready     = 1'b1;
    bus.flush        = 1'b0;
  endtask

  // Presents a valid instruction; caller adds forwarding/control overrides.
  task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                         input logic [31:0] pc4);
    bus.if_valid = 1'b1;
    bus.if_instr = ins(rs, rt, imm);
    bus.if_pc4   = pc4;
  endtask

  task automatic load_r8();
    idle();
    present(5'd0, 5'd8, 16'h0000, 32'h0);
    bus.ctl_regdst = 2'b01;
    bus.ctl_regwr  = 1'b1;
    bus.ctl_memrd  = 1'b1;
    tick();
    chk("lw_dst", 32'(bus.idex_dst), 32'd8);
    chk("lw_memrd", 32'(bus.idex_memrd), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // rs rt imm pc4 | regdst regwr memwr extop luop src1 src2 alufun | exm | mwb | a b st conba dst
    vecs[0] = '{5'd1, 5'd2, 16'h1820, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h1111, 32'h2222, 32'h2222, 32'h6080, 5'd3};
    vecs[1] = '{5'd0, 5'd2, 16'h2140, 32'h10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h5, 32'h2222, 32'h2222, 32'h8510, 5'd4};
    vecs[2] = '{5'd1, 5'd6, 16'hFFFE, 32'h200, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h21,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h1111, 32'hFFFF_FFFE, 32'h0, 32'h1F8, 5'd6};
    vecs[3] = '{5'd1, 5'd2, 16'h0000, 32'h40, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20,
                1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd2, 32'hBBBB,
                32'hAAAA, 32'hBBBB, 32'hBBBB, 32'h40, 5'd31};
    vecs[4] = '{5'd2, 5'd1, 16'h0000, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20,
                1'b1, 5'd2, 32'hC0C0, 1'b1, 5'd2, 32'hD0D0,
                32'hC0C0, 32'h1111, 32'h1111, 32'h0, 5'd26};
    vecs[5] = '{5'd2, 5'd7, 16'h1234, 32'h4, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h0F,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'hD0D0, 32'h1234_0000, 32'h0, 32'h48D4, 5'd7};
    vecs[6] = '{5'd0, 5'd0, 16'h0800, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20,
                1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hFFFF_FFFF,
                32'h0, 32'h0, 32'h0, 32'h2000, 5'd1};
    vecs[7] = '{5'd2, 5'd1, 16'h0008, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h20,
                1'b1, 5'd1, 32'h5A5A, 1'b0, 5'd0, 32'h0,
                32'hD0D0, 32'h8, 32'h5A5A, 32'h20, 5'd0};

    // Reset clears ID/EX and keeps stall_if low even with EX stalled.
    idle();
    bus.ex_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_stall", 32'(bus.stall_if), 32'd0);
    chk("rst_valid", 32'(bus.idex_valid), 32'd0);
    chk("rst_a", bus.idex_a, 32'h0);
    chk("rst_conba", bus.idex_conba, 32'h0);
    reset = 1'b0;
    idle();

    // A write to r0 is dropped and r0 still reads zero.
    bus.mwb_wr   = 1'b1;
    bus.mwb_addr = 5'd0;
    bus.mwb_data = 32'hFFFF_FFFF;
    tick();
    idle();
    present(5'd0, 5'd0, 16'h0000, 32'h0);
    tick();
    chk("r0_a", bus.idex_a, 32'h0);
    chk("r0_valid", 32'(bus.idex_valid), 32'd1);
    chk("r0_strobes", {29'd0, bus.idex_regwr, bus.idex_memrd, bus.idex_memwr}, 32'h0);

    // Seed r1/r2; with if_valid low these cycles advance as bubbles.
    idle();
    bus.mwb_wr   = 1'b1;
    bus.mwb_addr = 5'd1;
    bus.mwb_data = 32'h1111;
    tick();
    chk("nv_valid", 32'(bus.idex_valid), 32'd0);
    bus.mwb_addr = 5'd2;
    bus.mwb_data = 32'h2222;
    tick();

    for (int i = 0; i < NV; i++) begin
      idle();
      present(vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].pc4);
      bus.ctl_regdst  = vecs[i].regdst;
      bus.ctl_regwr   = vecs[i].regwr;
      bus.ctl_memwr   = vecs[i].memwr;
      bus.ctl_extop   = vecs[i].extop;
      bus.ctl_luop    = vecs[i].luop;
      bus.ctl_alusrc1 = vecs[i].src1;
      bus.ctl_alusrc2 = vecs[i].src2;
      bus.ctl_alufun  = vecs[i].alufun;
      bus.exm_wr      = vecs[i].exm_wr;
      bus.exm_addr    = vecs[i].exm_addr;
      bus.exm_data    = vecs[i].exm_data;
      bus.mwb_wr      = vecs[i].mwb_wr;
      bus.mwb_addr    = vecs[i].mwb_addr;
      bus.mwb_data    = vecs[i].mwb_data;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_if), 32'd0);
      tick();
      chk($sformatf("v%0d_a", i), bus.idex_a, vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), bus.idex_b, vecs[i].exp_b);
      chk($sformatf("v%0d_st", i), bus.idex_st, vecs[i].exp_st);
      chk($sformatf("v%0d_conba", i), bus.idex_conba, vecs[i].exp_conba);
      chk($sformatf("v%0d_dst", i), 32'(bus.idex_dst), 32'(vecs[i].exp_dst));
      chk($sformatf("v%0d_valid", i), 32'(bus.idex_valid), 32'd1);
      chk($sformatf("v%0d_regwr", i), 32'(bus.idex_regwr), 32'(vecs[i].regwr));
      chk($sformatf("v%0d_memwr", i), 32'(bus.idex_memwr), 32'(vecs[i].memwr));
      chk($sformatf("v%0d_alufun", i), 32'(bus.idex_alufun), 32'(vecs[i].alufun));
    end

    // EX/MEM beats MEM/WB; once EX/MEM drops, MEM/WB is used.
    idle();
    present(5'd5, 5'd0, 16'h0000, 32'h0);
    bus.exm_wr   = 1'b1;
    bus.exm_addr = 5'd5;
    bus.exm_data = 32'h11;
    bus.mwb_wr   = 1'b1;
    bus.mwb_addr = 5'd5;
    bus.mwb_data = 32'h22;
    tick();
    chk("fwd_exm", bus.idex_a, 32'h11);
    bus.exm_wr = 1'b0;
    tick();
    chk("fwd_mwb", bus.idex_a, 32'h22);

    // Load-use: one bubble, then the add picks up the loaded value.
    load_r8();
    idle();
    present(5'd8, 5'd1, 16'h4800, 32'h0);
    bus.ctl_regwr = 1'b1;
    #1;
    chk("lu_stall", 32'(bus.stall_if), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(bus.idex_valid), 32'd0);
    chk("lu_bubble_memrd", 32'(bus.idex_memrd), 32'd0);
    bus.exm_wr   = 1'b1;
    bus.exm_addr = 5'd8;
    bus.exm_data = 32'h5555;
    #1;
    chk("lu_release", 32'(bus.stall_if), 32'd0);
    tick();
    chk("lu_add_a", bus.idex_a, 32'h5555);
    chk("lu_add_b", bus.idex_b, 32'h1111);
    chk("lu_add_dst", 32'(bus.idex_dst), 32'd9);
    chk("lu_add_valid", 32'(bus.idex_valid), 32'd1);

    // Branch target with negative offset.
    idle();
    present(5'd1, 5'd2, 16'hFFFF, 32'h100);
    bus.ctl_extop = 1'b1;
    tick();
    chk("beq_conba", bus.idex_conba, 32'hFC);

    // Flush beats hold and load-use.
    load_r8();
    idle();
    present(5'd8, 5'd0, 16'h0000, 32'h0);
    bus.ex_ready = 1'b0;
    #1;
    chk("hold_stall", 32'(bus.stall_if), 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall_if), 32'd0);
    tick();
    chk("flush_valid", 32'(bus.idex_valid), 32'd0);
    chk("flush_memrd", 32'(bus.idex_memrd), 32'd0);

    // Hold freezes ID/EX while forwarding sources move; reset then clears it.
    idle();
    present(5'd3, 5'd0, 16'h0000, 32'h80);
    bus.exm_wr   = 1'b1;
    bus.exm_addr = 5'd3;
    bus.exm_data = 32'h77;
    tick();
    chk("pre_hold_a", bus.idex_a, 32'h77);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.exm_data = 32'h100 + 32'(i);
      bus.if_pc4   = 32'h200 + 32'(i);
      #1;
      chk($sformatf("hold%0d_stall", i), 32'(bus.stall_if), 32'd1);
      tick();
      chk($sformatf("hold%0d_a", i), bus.idex_a, 32'h77);
      chk($sformatf("hold%0d_conba", i), bus.idex_conba, 32'h80);
      chk($sformatf("hold%0d_valid", i), 32'(bus.idex_valid), 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("rst2_stall", 32'(bus.stall_if), 32'd0);
    tick();
    chk("rst2_valid", 32'(bus.idex_valid), 32'd0);
    chk("rst2_a", bus.idex_a, 32'h0);
    chk("rst2_conba", bus.idex_conba, 32'h0);
    reset = 1'b0;

    // Register file contents are cleared by reset too.
    idle();
    present(5'd1, 5'd2, 16'h0000, 32'h0);
    tick();
    chk("rst2_rf_r1", bus.idex_a, 32'h0);
    chk("rst2_rf_r2", bus.idex_st, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
